// File: rtl/fpcvt_decode.sv
// Sequential FPCVT float-to-linear decoder: rebuilds D = (-1)^S * F * 2^E by
// shifting the significand one bit per clock under an IDLE/SHIFT/DONE FSM.
module fpcvt_decode #(
  parameter int E_W = 3,
  parameter int F_W = 5,
  parameter int D_W = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           S,
  input  logic [E_W-1:0] E,
  input  logic [F_W-1:0] F,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] D
);

  // Handshakes: a request transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready. out_valid
  // and D stay stable until that transfer, and in_ready is high only in IDLE.

  generate
    if (D_W < F_W + (1 << E_W)) begin : g_width_check
      $error("fpcvt_decode: D_W too small for F_W + 2**E_W");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t         r_state;
  logic           r_sign;
  logic [E_W-1:0] r_count;
  logic [D_W-2:0] r_mag;
  logic [D_W-1:0] r_d;
  logic           r_out_valid;

  logic [D_W-1:0] w_mag_ext;
  logic [D_W-1:0] w_result;

  // Magnitude sits one bit below D's width, so negating zero stays zero.
  assign w_mag_ext = {1'b0, r_mag};
  assign w_result  = r_sign ? -w_mag_ext : w_mag_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_count     <= '0;
      r_mag       <= '0;
      r_d         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign  <= S;
            r_count <= E;
            r_mag   <= {{(D_W-1-F_W){1'b0}}, F};
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_count != '0) begin
            r_mag   <= r_mag << 1;
            r_count <= r_count - E_W'(1);
          end else begin
            r_d         <= w_result;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign D         = r_d;

endmodule

// File: doc/fpcvt_decode.md
Name: fpcvt_decode

Overview:
Sequential inverse of the FPCVT linear-to-float converter. It accepts an 8-bit floating-point word (sign S, exponent E[2:0], significand F[4:0]) and reconstructs the 13-bit two's-complement linear value D = (-1)^S * F * 2^E. The significand is shifted one bit per clock under a small FSM with valid/ready handshakes on both sides. The block feeds the display and readback path that consumes FPCVT-encoded samples.

Parameters:
E_W, 3, exponent width; shift count range 0..2^E_W-1.
F_W, 5, significand width.
D_W, 13, output width; must satisfy D_W >= F_W + 2^E_W; checked at elaboration.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  S/E/F present a conversion request.
in_ready  out  1  block can accept a request; high only in IDLE.
S  in  1  sign, 1 = negative.
E  in  E_W  exponent (left-shift count).
F  in  F_W  significand (unsigned magnitude).
out_valid  out  1  D holds a completed result.
out_ready  in  1  consumer accepts D.
D  out  D_W  two's-complement result, registered.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, D=0, internal mag/count/sign=0. An in-flight conversion is discarded; no partial result appears.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid=1 (accept edge): latch sign<=S, count<=E, mag<={zeros,F} (D_W-1 bits); go to SHIFT. in_valid=0: stay.
- SHIFT: in_ready=0. If count!=0: mag<=mag<<1, count<=count-1, stay. If count==0: D<= sign ? -mag : mag (D_W-bit two's complement), out_valid<=1, go to DONE.
- DONE: in_ready=0, D and out_valid held stable. On out_ready=1: out_valid<=0, go to IDLE. D keeps its last value after the handshake. The next request can be accepted no earlier than the following cycle.
- Latency: out_valid rises E+1 clock edges after the accept edge (E=0 gives 1; E=7 gives 8). Throughput: at most one conversion per E+3 cycles with out_ready held high.
- Arithmetic:
  - Magnitude never overflows: max 31<<7 = 3968 < 4096.
  - S=1 with F=0 yields D=0, never -0 or -4096.
  - Denormal inputs (F MSB=0 with E>0) are decoded literally, with no normalisation and no error.
- in_valid while in_ready=0 is ignored; S/E/F may change freely outside the accept edge.
- out_ready while out_valid=0 has no effect.
- Only D, out_valid and in_ready are outputs. No combinational path from inputs to outputs, except that in_ready is decoded from state.

Test Plan:
- Reset, then S=0,E=7,F=31, in_valid one cycle -> out_valid rises 8 edges after accept, D=0_1111_1000_0000 (3968).
- S=1,E=7,F=31 (FPCVT encoding of -4096 and -3968) -> D=1_0000_1000_0000 (-3968), latency 8.
- S=0,E=4,F=26 (FPCVT of 422) -> D=0_0001_1010_0000 (416), latency 5. Then S=1,E=4,F=26 -> D=1_1110_0110_0000 (-416).
- Boundaries: S=0,E=0,F=1 -> D=1, out_valid 1 edge after accept. S=1,E=0,F=0 -> D=0. S=0,E=3,F=5 (denormal) -> D=40.
- Backpressure: hold out_ready=0 for 4 cycles after out_valid. D and out_valid must stay stable, in_ready=0, and a new in_valid pulse during SHIFT/DONE must be ignored (no second result). Release out_ready -> IDLE next edge, in_ready=1.
- Reset mid-SHIFT (E=7, assert rst 3 cycles after accept, asynchronously mid-cycle) -> out_valid=0, D=0, in_ready=1 immediately. After release, a fresh S=0,E=1,F=16 request -> D=32 with latency 2.
